// File: rtl/regfile_wb_8x16.sv
// regfile_wb_8x16: write-back pipeline register, 8 x DATA_W register array
// with one-hot commit enables, two combinational read ports with bypass of
// the pending write, and a per-register pending scoreboard for decode.
module regfile_wb_8x16 #(
  parameter int DATA_W  = 16,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic              wb_we,
  input  logic [2:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              stall,
  input  logic              flush,
  input  logic              iss_valid,
  input  logic              iss_we,
  input  logic [2:0]        iss_rd,
  input  logic [2:0]        ra_addr,
  input  logic [2:0]        rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              ra_pend,
  output logic              rb_pend,
  output logic [7:0]        pend
);

  // Architectural state
  logic [DATA_W-1:0] regs_reg [8];
  logic              s_valid_reg;
  logic              s_we_reg;
  logic [2:0]        s_rd_reg;
  logic [DATA_W-1:0] s_data_reg;
  logic [7:0]        pend_reg;

  // Decoded per-register controls
  logic              commit;
  logic              pend_clear_all;
  logic [7:0]        wr_en;
  logic [7:0]        set_vec;
  logic [7:0]        pend_next;

  // A stalled stage neither commits nor advances; the held entry is still
  // allowed to commit on a flush edge because flush only drops the incoming one.
  assign commit         = s_valid_reg & s_we_reg & ~stall;
  assign pend_clear_all = flush & ~stall;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_reg_ctl
      // One-hot write enable: at most one register written per edge.
      assign wr_en[gi]   = commit & (s_rd_reg == 3'(gi));
      // Register 0 never becomes pending when it is hardwired to zero.
      assign set_vec[gi] = iss_valid & iss_we & (iss_rd == 3'(gi))
                           & !(R0_ZERO && (gi == 0));
      // A new producer supersedes the one committing in the same cycle.
      assign pend_next[gi] = pend_clear_all ? 1'b0 :
                             set_vec[gi]    ? 1'b1 :
                             wr_en[gi]      ? 1'b0 : pend_reg[gi];
    end
  endgenerate

  // Register array commit from the write-back stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_en[i]) regs_reg[i] <= s_data_reg;
      end
    end
  end

  // Write-back stage register: hold on stall, drop the incoming result on flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid_reg <= 1'b0;
      s_we_reg    <= 1'b0;
      s_rd_reg    <= 3'd0;
      s_data_reg  <= '0;
    end else if (!stall) begin
      if (flush) begin
        s_valid_reg <= 1'b0;
      end else begin
        s_valid_reg <= wb_valid;
        s_we_reg    <= wb_we;
        s_rd_reg    <= wb_rd;
        s_data_reg  <= wb_data;
      end
    end
  end

  // Pending scoreboard update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_reg <= 8'd0;
    else     pend_reg <= pend_next;
  end

  // Read with R0 forcing and bypass of the staged (possibly stalled) write.
  function automatic logic [DATA_W-1:0] read_port(input logic [2:0] addr);
    if (R0_ZERO && addr == 3'd0)
      return '0;
    else if (s_valid_reg && s_we_reg && s_rd_reg == addr)
      return s_data_reg;
    else
      return regs_reg[addr];
  endfunction

  // Combinational read ports and registered-only pending flags
  always_comb begin
    ra_data = read_port(ra_addr);
    rb_data = read_port(rb_addr);
    ra_pend = pend_reg[ra_addr];
    rb_pend = pend_reg[rb_addr];
    pend    = pend_reg;
  end

endmodule

// File: tb/tb_regfile_wb_8x16.sv
// tb_regfile_wb_8x16: scoreboard bench. Each cycle the reference model's
// expected outputs are pushed when stimulus is driven and popped/compared
// once the DUT outputs have settled; directed checks cover the key cases.
module tb_regfile_wb_8x16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_we, stall, flush, iss_valid, iss_we;
  logic [2:0]  wb_rd, iss_rd, ra_addr, rb_addr;
  logic [15:0] wb_data, ra_data, rb_data;
  logic        ra_pend, rb_pend;
  logic [7:0]  pend;

  regfile_wb_8x16 dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .flush(flush),
    .iss_valid(iss_valid), .iss_we(iss_we), .iss_rd(iss_rd),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data),
    .ra_pend(ra_pend), .rb_pend(rb_pend), .pend(pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rap;
    logic        rbp;
    logic [7:0]  pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  logic [15:0] m_r [8];
  logic        m_sv, m_swe;
  logic [2:0]  m_srd;
  logic [15:0] m_sdata;
  logic [7:0]  m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
    m_sv = 0; m_swe = 0; m_srd = 0; m_sdata = 0; m_pend = 0;
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 16'h0;
    if (m_sv && m_swe && m_srd == a) return m_sdata;
    return m_r[a];
  endfunction

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic       commit;
    logic [7:0] np;
    commit = m_sv && m_swe && !stall;
    for (int i = 0; i < 8; i++) begin
      if (flush && !stall)                                     np[i] = 1'b0;
      else if (iss_valid && iss_we && iss_rd == i && i != 0)   np[i] = 1'b1;
      else if (commit && m_srd == i)                           np[i] = 1'b0;
      else                                                     np[i] = m_pend[i];
    end
    m_pend = np;
    if (commit) m_r[m_srd] = m_sdata;
    if (!stall) begin
      if (flush) m_sv = 1'b0;
      else begin
        m_sv = wb_valid; m_swe = wb_we; m_srd = wb_rd; m_sdata = wb_data;
      end
    end
  endtask

  task automatic idle();
    wb_valid = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    stall = 0; flush = 0; iss_valid = 0; iss_we = 0; iss_rd = 0;
  endtask

  task automatic issue(input logic [2:0] rd);
    iss_valid = 1; iss_we = 1; iss_rd = rd;
  endtask

  task automatic wb(input logic [2:0] rd, input logic [15:0] d);
    wb_valid = 1; wb_we = 1; wb_rd = rd; wb_data = d;
  endtask

  // Push the model prediction for this cycle, let the DUT settle, pop and compare.
  task automatic settle();
    exp_t e;
    e.ra = m_read(ra_addr); e.rb = m_read(rb_addr);
    e.rap = m_pend[ra_addr]; e.rbp = m_pend[rb_addr]; e.pend = m_pend;
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    check("sb_ra_data", 32'(ra_data), 32'(e.ra));
    check("sb_rb_data", 32'(rb_data), 32'(e.rb));
    check("sb_ra_pend", 32'(ra_pend), 32'(e.rap));
    check("sb_rb_pend", 32'(rb_pend), 32'(e.rbp));
    check("sb_pend",    32'(pend),    32'(e.pend));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 1; idle(); ra_addr = 3; rb_addr = 5;
    model_reset();
    #1;
    check("reset_ra", 32'(ra_data), 0);
    check("reset_rb", 32'(rb_data), 0);
    check("reset_pend", 32'(pend), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;

    // Write/read latency on r3
    idle(); issue(3); ra_addr = 3; rb_addr = 1; settle(); tick();
    idle(); wb(3, 16'hBEEF); settle();
    check("no_mem_bypass", 32'(ra_data), 0);
    check("pend3_set", 32'(pend[3]), 1);
    tick();
    idle(); settle();
    check("bypass_beef", 32'(ra_data), 32'h0000BEEF);
    check("pend3_held", 32'(ra_pend), 1);
    tick();
    idle(); settle();
    check("array_beef", 32'(ra_data), 32'h0000BEEF);
    check("pend3_clr", 32'(pend[3]), 0);
    check("other_reg", 32'(rb_data), 0);
    tick();

    // Stall holds the commit; bypass value stable; flush ignored while stalled
    idle(); issue(5); rb_addr = 5; settle(); tick();
    idle(); wb(5, 16'h1234); settle(); tick();
    for (int k = 0; k < 3; k++) begin
      idle(); stall = 1; flush = (k == 1); wb(5, 16'h5555); issue(6); settle();
      check("stall_bypass", 32'(rb_data), 32'h00001234);
      check("stall_pend5", 32'(rb_pend), 1);
      tick();
    end
    idle(); settle();
    check("post_stall_bypass", 32'(rb_data), 32'h00001234);
    check("post_stall_pend5", 32'(rb_pend), 1);
    tick();
    idle(); settle();
    check("stall_commit", 32'(rb_data), 32'h00001234);
    check("stall_pend5_clr", 32'(rb_pend), 0);
    tick();

    // Scoreboard race on r2
    idle(); issue(2); ra_addr = 2; settle(); tick();
    idle(); wb(2, 16'h0022); settle(); tick();
    idle(); issue(2); settle(); tick();
    idle(); settle();
    check("race_set_wins", 32'(pend[2]), 1);
    wb(2, 16'h0222); tick();
    idle(); settle(); tick();
    idle(); settle();
    check("commit_clears", 32'(pend[2]), 0);
    check("race_data", 32'(ra_data), 32'h00000222);
    tick();

    // Flush: held r4 commits, incoming r6 dropped, scoreboard cleared
    idle(); issue(6); settle(); tick();
    idle(); wb(4, 16'h00AA); issue(4); settle(); tick();
    idle(); flush = 1; wb(6, 16'h6666); issue(1); settle(); tick();
    idle(); ra_addr = 4; rb_addr = 6; settle();
    check("flush_r4", 32'(ra_data), 32'h000000AA);
    check("flush_r6", 32'(rb_data), 32'h0);
    check("flush_pend", 32'(pend), 0);
    tick();

    // R0 hardwired to zero
    idle(); wb(0, 16'hFFFF); issue(0); ra_addr = 0; settle(); tick();
    idle(); settle();
    check("r0_bypass_zero", 32'(ra_data), 0);
    check("r0_pend", 32'(pend[0]), 0);
    tick();
    idle(); settle();
    check("r0_array_zero", 32'(ra_data), 0);
    tick();

    // Back-to-back writes to r7
    idle(); wb(7, 16'h0007); ra_addr = 7; settle(); tick();
    idle(); wb(7, 16'h0077); settle();
    check("b2b_first", 32'(ra_data), 32'h00000007);
    tick();
    idle(); settle();
    check("b2b_newest", 32'(ra_data), 32'h00000077);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      wb_valid  = 1'($urandom_range(0, 1));
      wb_we     = ($urandom_range(0, 3) != 0);
      wb_rd     = 3'($urandom);
      wb_data   = 16'($urandom);
      stall     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      iss_valid = 1'($urandom_range(0, 1));
      iss_we    = ($urandom_range(0, 3) != 0);
      iss_rd    = 3'($urandom);
      ra_addr   = 3'($urandom);
      rb_addr   = 3'($urandom);
      settle();
      tick();
    end

    // Reset mid-run with a full stage
    idle(); wb(3, 16'h3333); issue(3); ra_addr = 3; rb_addr = 7; settle(); tick();
    idle(); settle();
    rst = 1; #1;
    check("midrst_ra", 32'(ra_data), 0);
    check("midrst_rb", 32'(rb_data), 0);
    check("midrst_pend", 32'(pend), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    idle(); settle();
    check("after_rst_pend", 32'(pend), 0);
    check("after_rst_ra", 32'(ra_data), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
